spart_rx: RTL and testbench

//  Receive half of the SPART. Oversamples the serial rxd line on baud-generator ticks, frames
//  8N1 characters (start, DATA_BITS data LSB-first, one stop) and holds the received byte for
//  the bus interface. Drives the rda status bit read by the driver; reports framing and overrun

---
 rtl/spart_rx.sv | 148 ++++++++++++++
 tb/tb_spart_rx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_rx.sv
// spart_rx: receive half of the SPART.
// Oversamples rxd on baud ticks, frames 8N1 characters LSB-first and holds the last
// good byte for the bus. Reports rda, plus sticky framing and overrun errors.
module spart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 rxd,
    input  logic                 clr_rda,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 framing_err,
    output logic                 overrun_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state_q;
    logic                   rxd_meta_q;
    logic                   rxd_s_q;
    logic                   armed_q;
    logic [TW-1:0]          tick_q;
    logic [TW-1:0]          tick_d;
    logic [BW-1:0]          bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_d;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rda_q;
    logic                   framing_err_q;
    logic                   overrun_err_q;

    // Next values for the tick counter and the right-shifting (LSB-first) data register
    always_comb begin
        tick_d  = tick_q + 1'b1;
        shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
    end

    // Two-flop synchroniser for the asynchronous rxd pin; resets to the idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    // Framing FSM and status flags; a set later in this block overrides an earlier clear
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            armed_q       <= 1'b0;
            tick_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rda_q         <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            if (clr_rda) begin
                rda_q         <= 1'b0;
                framing_err_q <= 1'b0;
                overrun_err_q <= 1'b0;
            end
            if (enable) begin
                case (state_q)
                    IDLE: begin
                        if (rxd_s_q) begin
                            armed_q <= 1'b1;
                        end else if (armed_q) begin
                            state_q <= START;
                            tick_q  <= '0;
                        end
                    end
                    START: begin
                        if (tick_q == TICK_MID) begin
                            if (!rxd_s_q) begin
                                state_q <= DATA;
                                tick_q  <= '0;
                                bit_q   <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                    DATA: begin
                        if (tick_q == TICK_LAST) begin
                            shift_q <= shift_d;
                            tick_q  <= '0;
                            bit_q   <= bit_q + 1'b1;
                            if (bit_q == BIT_LAST) begin
                                state_q <= STOP;
                            end
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                    STOP: begin
                        if (tick_q == TICK_LAST) begin
                            state_q <= IDLE;
                            armed_q <= 1'b0;
                            tick_q  <= '0;
                            if (rxd_s_q) begin
                                rx_data_q <= shift_q;
                                rda_q     <= 1'b1;
                                if (rda_q && !clr_rda) begin
                                    overrun_err_q <= 1'b1;
                                end
                            end else begin
                                framing_err_q <= 1'b1;
                            end
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_data     = rx_data_q;
    assign rda         = rda_q;
    assign framing_err = framing_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_spart_rx.sv
// tb_spart_rx: scoreboard bench for spart_rx.
// Stimulus pushes the expected output tuple {rx_data, rda, framing_err, overrun_err}
// for every visible change it provokes; a negedge monitor pops and compares whenever
// the DUT outputs change, so any unexpected change is also caught.
module tb_spart_rx;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    typedef struct {
        logic [10:0] value;
        string       tag;
    } expect_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       rxd = 1'b1;
    logic       clrRda = 1'b0;
    logic [7:0] rxData;
    logic       rda;
    logic       framingErr;
    logic       overrunErr;

    expect_t     expQ[$];
    expect_t     monExp;
    int          checks = 0;
    int          failures = 0;
    int          tickDiv = 1;
    bit          monActive = 1'b0;
    logic [10:0] prevOut;
    logic [10:0] curOut;

    // 10 ns system clock
    always #5 clk = ~clk;

    spart_rx #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rxd        (rxd),
        .clr_rda    (clrRda),
        .rx_data    (rxData),
        .rda        (rda),
        .framing_err(framingErr),
        .overrun_err(overrunErr)
    );

    function automatic logic [10:0] packOut();
        return {rxData, rda, framingErr, overrunErr};
    endfunction

    task automatic checkOutput(input string tag, input logic [10:0] actual, input logic [10:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got data=%h rda=%b fe=%b oe=%b, want data=%h rda=%b fe=%b oe=%b",
                     tag, actual[10:3], actual[2], actual[1], actual[0],
                     expected[10:3], expected[2], expected[1], expected[0]);
        end
    endtask

    task automatic expectEvent(input string tag, input logic [7:0] data, input logic r,
                               input logic fe, input logic oe);
        expect_t e;
        e.value = {data, r, fe, oe};
        e.tag   = tag;
        expQ.push_back(e);
    endtask

    // Drive one frame: start, 8 data bits LSB-first, stop; line is left at the stop level
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int bitClks);
        rxd = 1'b0;
        repeat (bitClks) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (bitClks) @(posedge clk);
            #1;
        end
        rxd = stopBit;
        repeat (bitClks) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseClr();
        clrRda = 1'b1;
        @(posedge clk);
        #1;
        clrRda = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 64 && expQ.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (expQ.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: pending=%0d expected events, want 0", tag, expQ.size());
            expQ.delete();
        end
    endtask

    // Baud tick generator: enable high every tickDiv clocks
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(posedge clk);
            #1;
            phase  = (phase + 1) % tickDiv;
            enable = (phase == 0);
        end
    end

    // Monitor: every change of the output tuple must match the next scoreboard entry
    always @(negedge clk) begin
        if (monActive) begin
            curOut = packOut();
            if (curOut !== prevOut) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_change: got data=%h rda=%b fe=%b oe=%b, want no change from %h",
                             curOut[10:3], curOut[2], curOut[1], curOut[0], prevOut);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput(monExp.tag, curOut, monExp.value);
                end
                prevOut = curOut;
            end
        end
    end

    // Directed stimulus sequence
    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_state", packOut(), 11'd0);
        prevOut   = packOut();
        monActive = 1'b1;
        idle(4);

        $display("[TB] test 1: 0xA5 and clear");
        expectEvent("t1_rx_a5", 8'hA5, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'hA5, 1'b1, 16);
        waitDrain("t1_rx_a5");
        expectEvent("t1_clr", 8'hA5, 1'b0, 1'b0, 1'b0);
        pulseClr();
        waitDrain("t1_clr");
        idle(8);

        $display("[TB] test 2: start glitch then 0x00");
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(30);
        expectEvent("t2_rx_00", 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b1, 16);
        waitDrain("t2_rx_00");
        expectEvent("t2_clr", 8'h00, 1'b0, 1'b0, 1'b0);
        pulseClr();
        waitDrain("t2_clr");
        idle(8);

        $display("[TB] test 3: framing error, break, then 0x11");
        expectEvent("t3_framing", 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h5A, 1'b0, 16);
        waitDrain("t3_framing");
        expectEvent("t3_clr_fe", 8'h00, 1'b0, 1'b0, 1'b0);
        pulseClr();
        idle(40);
        waitDrain("t3_clr_fe");
        rxd = 1'b1;
        idle(8);
        expectEvent("t3_rx_11", 8'h11, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h11, 1'b1, 16);
        waitDrain("t3_rx_11");
        expectEvent("t3_clr", 8'h11, 1'b0, 1'b0, 1'b0);
        pulseClr();
        waitDrain("t3_clr");
        idle(8);

        $display("[TB] test 4: overrun");
        expectEvent("t4_rx_3c", 8'h3C, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h3C, 1'b1, 16);
        waitDrain("t4_rx_3c");
        idle(8);
        expectEvent("t4_overrun_c3", 8'hC3, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'hC3, 1'b1, 16);
        waitDrain("t4_overrun_c3");
        expectEvent("t4_clr", 8'hC3, 1'b0, 1'b0, 1'b0);
        pulseClr();
        waitDrain("t4_clr");
        idle(8);

        $display("[TB] test 5: clear on the commit cycle");
        expectEvent("t5_rx_24", 8'h24, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h24, 1'b1, 16);
        waitDrain("t5_rx_24");
        idle(8);
        expectEvent("t5_commit_7e", 8'h7E, 1'b1, 1'b0, 1'b0);
        fork
            applyStimulus(8'h7E, 1'b1, 16);
            begin
                repeat (154) @(posedge clk);
                #1;
                clrRda = 1'b1;
                @(posedge clk);
                #1;
                clrRda = 1'b0;
            end
        join
        waitDrain("t5_commit_7e");
        idle(8);

        $display("[TB] test 6: reset mid-character");
        expectEvent("t6_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        fork
            applyStimulus(8'hF8, 1'b1, 16);
            begin
                repeat (72) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        waitDrain("t6_reset");
        idle(8);
        expectEvent("t6_rx_81", 8'h81, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h81, 1'b1, 16);
        waitDrain("t6_rx_81");
        expectEvent("t6_clr", 8'h81, 1'b0, 1'b0, 1'b0);
        pulseClr();
        waitDrain("t6_clr");
        idle(8);

        $display("[TB] test 7: slow baud ticks");
        tickDiv = 4;
        idle(16);
        expectEvent("t7_rx_96", 8'h96, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h96, 1'b1, 64);
        waitDrain("t7_rx_96");
        idle(16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
